regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised register file for the pipelined core: 2 async read ports, 1 sync write port.
//  Hardwired zero register. Per-register pending-write scoreboard: decode marks a destination
//  as busy; writeback clears it. Sits between decode (reads, issue) and writeback (we3/wa3/wd3).
// PARAMETERS
//  N      64  data width (bits)
//  NREGS  32  number of architectural registers (power of 2, >=4)
//  ZREG   31  index of the hardwired-zero register (XZR)
//  A      $clog2(NREGS)  address width (localparam, derived)
// PORTS
//  clk       in   1      clock, all state on rising edge
//  reset     in   1      asynchronous, active-high reset
//  ra1,ra2   in   A      read addresses
//  rd1,rd2   out  N      read data
//  rdy1,rdy2 out  1      1 = register at raX has no pending write
//  iss_en    in   1      issue strobe: mark iss_wa pending
//  iss_wa    in   A      destination register of issued instruction
//  we3       in   1      writeback enable
//  wa3       in   A      writeback address
//  wd3       in   N      writeback data
//  pend_cnt  out  A+1    number of registers currently pending
//  wb_err    out  1      sticky: writeback to a register that was not pending
// BEHAVIOUR
//  Reset (async, immediate): reg[i] <= i zero-extended for i in 1..NREGS-1, i != ZREG;
//   reg[0] <= 0; all pending <= 0; pend_cnt = 0; wb_err = 0; rdy1 = rdy2 = 1.
//   Reset asserted mid-operation discards all in-flight pending marks.
//  Read: combinational. rdX = (raX==ZREG) ? 0 : reg[raX]. rdyX = (raX==ZREG) ? 1 : ~pending[raX].
//  Write: on posedge, if we3 && wa3 != ZREG: reg[wa3] <= wd3; visible on rdX the next cycle.
//   Writes to ZREG are discarded; no pending change, no error.
//  Scoreboard, per posedge, evaluated for each register r != ZREG:
//   set = iss_en && iss_wa==r;  clr = we3 && wa3==r.
//   set && clr -> pending[r] stays/becomes 1 (new producer wins; data still written).
//   set only -> pending[r] <= 1 (re-issue to an already pending reg: no change, no error).
//   clr only -> pending[r] <= 0.
//   iss_en with iss_wa==ZREG -> ignored.
//  wb_err: set on posedge when we3 && wa3!=ZREG && !pending[wa3] && !(iss_en && iss_wa==wa3);
//   cleared only by reset.
//  pend_cnt: registered popcount of pending, updated the same edge as pending; max NREGS-1.
//  Latency: issue -> rdy low next cycle; writeback -> rdy high and data valid next cycle.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: same-cycle write forwarding. If we3 && wa3==raX && wa3!=ZREG,
//   then rdX = wd3 and rdyX = 1 combinationally (unless iss_en && iss_wa==raX: rdyX = 0).
//  Not defined: reads return the stored value; write visible only after the clock edge;
//   rdyX reflects the registered pending bit only.
// TESTING
//  Reset, then read ra1=5, ra2=31 -> rd1=5, rd2=0, rdy1=rdy2=1, pend_cnt=0.
//  we3=1 wa3=31 wd3=64'hDEAD -> next cycle rd(31)=0, wb_err=0; we3 wa3=3 wd3=64'hDEAD -> rd(3)=DEAD next cycle.
//  iss_en iss_wa=7 -> next cycle rdy(7)=0, pend_cnt=1; we3 wa3=7 wd3=42 -> next cycle rdy(7)=1, rd(7)=42, pend_cnt=0.
//  Same cycle iss_en iss_wa=9 and we3 wa3=9 wd3=1 (9 pending) -> next cycle rd(9)=1, rdy(9)=0, wb_err=0.
//  we3 wa3=4 with 4 not pending -> wb_err=1 next cycle, stays 1; reset mid-stream with 3 regs pending -> all rdy=1, pend_cnt=0, wb_err=0.
//  With REGFILE_BYPASS_EN: ra1=6, we3 wa3=6 wd3=77 -> rd1=77 same cycle; without: rd1=6 same cycle, 77 after edge.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: register file with two asynchronous read ports, one synchronous
// write port, a hardwired-zero register and a per-register pending-write
// scoreboard. Decode marks destinations busy on issue and writeback clears them.
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_sb #(
   parameter  int unsigned N     = 64,
   parameter  int unsigned NREGS = 32,
   parameter  int unsigned ZREG  = 31,
   localparam int unsigned A     = $clog2(NREGS)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [A-1:0] ra1,
   input  logic [A-1:0] ra2,
   output logic [N-1:0] rd1,
   output logic [N-1:0] rd2,
   output logic         rdy1,
   output logic         rdy2,
   input  logic         iss_en,
   input  logic [A-1:0] iss_wa,
   input  logic         we3,
   input  logic [A-1:0] wa3,
   input  logic [N-1:0] wd3,
   output logic [A:0]   pend_cnt,
   output logic         wb_err
);

   localparam logic [A-1:0] ZA = A'(ZREG);

   logic [N-1:0]     regs [NREGS];
   logic [NREGS-1:0] pending;
   logic [NREGS-1:0] pending_nxt;
   logic [A:0]       cnt_nxt;
   logic             wr_ok;
   logic             err_nxt;

   assign wr_ok = we3 && (wa3 != ZA);

   // Data storage: reset to index values, then accept writebacks (ZREG never written)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            regs[i] <= (i == ZREG) ? '0 : N'(i);
         end
      end else if (wr_ok) begin
         regs[wa3] <= wd3;
      end
   end

   // Next scoreboard state: issue takes priority over a same-edge writeback
   always_comb begin
      pending_nxt = pending;
      for (int unsigned r = 0; r < NREGS; r++) begin
         if (r != ZREG) begin
            if (iss_en && (iss_wa == A'(r))) begin
               pending_nxt[r] = 1'b1;
            end else if (we3 && (wa3 == A'(r))) begin
               pending_nxt[r] = 1'b0;
            end
         end else begin
            pending_nxt[r] = 1'b0;
         end
      end
   end

   // Popcount of the next pending vector so pend_cnt moves on the same edge
   always_comb begin
      cnt_nxt = '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
         cnt_nxt = cnt_nxt + (A+1)'(pending_nxt[i]);
      end
   end

   // Writeback to a register with no outstanding producer (and none issuing now)
   always_comb begin
      err_nxt = wr_ok && !pending[wa3] && !(iss_en && (iss_wa == wa3));
   end

   // Scoreboard, counter and sticky error registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending  <= '0;
         pend_cnt <= '0;
         wb_err   <= 1'b0;
      end else begin
         pending  <= pending_nxt;
         pend_cnt <= cnt_nxt;
         if (err_nxt) begin
            wb_err <= 1'b1;
         end
      end
   end

   // Read port 1: stored value, optional forwarding, zero register overrides all
   always_comb begin
      rd1  = regs[ra1];
      rdy1 = ~pending[ra1];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (wa3 == ra1)) begin
         rd1  = wd3;
         rdy1 = !(iss_en && (iss_wa == ra1));
      end
`else
`endif
      if (ra1 == ZA) begin
         rd1  = '0;
         rdy1 = 1'b1;
      end
   end

   // Read port 2: identical behaviour to port 1
   always_comb begin
      rd2  = regs[ra2];
      rdy2 = ~pending[ra2];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (wa3 == ra2)) begin
         rd2  = wd3;
         rdy2 = !(iss_en && (iss_wa == ra2));
      end
`else
`endif
      if (ra2 == ZA) begin
         rd2  = '0;
         rdy2 = 1'b1;
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed steps followed by randomized
// traffic, all checked against an array-based reference model.
module tb_regfile_sb;

   localparam int unsigned N     = 64;
   localparam int unsigned NREGS = 32;
   localparam int unsigned ZREG  = 31;
   localparam int unsigned A     = 5;

   logic         clk = 1'b0;
   logic         reset;
   logic [A-1:0] ra1, ra2, iss_wa, wa3;
   logic [N-1:0] rd1, rd2, wd3;
   logic         rdy1, rdy2, iss_en, we3, wb_err;
   logic [A:0]   pend_cnt;

   int ncmp  = 0;
   int nfail = 0;

   // reference model state
   logic [N-1:0] mreg [NREGS];
   bit           mpend [NREGS];
   bit           merr;

   regfile_sb #(.N(N), .NREGS(NREGS), .ZREG(ZREG)) dut (
      .clk(clk), .reset(reset),
      .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .rdy1(rdy1), .rdy2(rdy2),
      .iss_en(iss_en), .iss_wa(iss_wa),
      .we3(we3), .wa3(wa3), .wd3(wd3),
      .pend_cnt(pend_cnt), .wb_err(wb_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < int'(NREGS); i++) begin
         mreg[i]  = (i == int'(ZREG)) ? '0 : N'(i);
         mpend[i] = 1'b0;
      end
      merr = 1'b0;
   endtask

   function automatic logic [N-1:0] exp_rd(input int ra);
      if (ra == int'(ZREG)) return '0;
`ifdef REGFILE_BYPASS_EN
      if (we3 && int'(wa3) == ra) return wd3;
`endif
      return mreg[ra];
   endfunction

   function automatic logic exp_rdy(input int ra);
      if (ra == int'(ZREG)) return 1'b1;
`ifdef REGFILE_BYPASS_EN
      if (we3 && int'(wa3) == ra) return !(iss_en && int'(iss_wa) == ra);
`endif
      return !mpend[ra];
   endfunction

   function automatic int model_count();
      int c = 0;
      foreach (mpend[i]) if (mpend[i]) c++;
      return c;
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".rd1"},  rd1, exp_rd(int'(ra1)));
      chk({tag, ".rd2"},  rd2, exp_rd(int'(ra2)));
      chk({tag, ".rdy1"}, N'(rdy1), N'(exp_rdy(int'(ra1))));
      chk({tag, ".rdy2"}, N'(rdy2), N'(exp_rdy(int'(ra2))));
      chk({tag, ".cnt"},  N'(pend_cnt), N'(model_count()));
      chk({tag, ".err"},  N'(wb_err), N'(merr));
   endtask

   // One clock cycle: drive after the falling edge, check before the rising
   // edge, then advance the model with the inputs that were captured.
   task automatic cyc(input string tag, input int a1, input int a2,
                      input bit ie, input int iw, input bit we, input int wa,
                      input logic [N-1:0] wd);
      ra1 = A'(a1); ra2 = A'(a2); iss_en = ie; iss_wa = A'(iw);
      we3 = we; wa3 = A'(wa); wd3 = wd;
      #1;
      check_all(tag);
      @(posedge clk);
      if (we && wa != int'(ZREG)) begin
         if (!mpend[wa] && !(ie && iw == wa)) merr = 1'b1;
         mreg[wa]  = wd;
         mpend[wa] = 1'b0;
      end
      if (ie && iw != int'(ZREG)) mpend[iw] = 1'b1;
      @(negedge clk);
   endtask

   // Asynchronous reset pulse placed mid-cycle, checked while still asserted
   task automatic async_reset(input string tag);
      ra1 = A'(10); ra2 = A'(11); iss_en = 0; we3 = 0;
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_all(tag);
      #1;
      reset = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; ra1 = '0; ra2 = '0; iss_en = 0; iss_wa = '0;
      we3 = 0; wa3 = '0; wd3 = '0;
      model_reset();
      @(negedge clk);
      #1;
      check_all("reset_held");
      reset = 1'b0;
      @(negedge clk);

      cyc("rd_init",   5, 31, 0, 0, 0, 0,  '0);
      cyc("wr_zreg",   0, 31, 0, 0, 1, 31, 64'hDEAD);
      cyc("zreg_rd",  31,  3, 0, 0, 1, 3,  64'hDEAD);
      cyc("rd3",      31,  3, 0, 0, 0, 0,  '0);
      cyc("iss7",      7,  0, 1, 7, 0, 0,  '0);
      cyc("wb7",       7,  0, 0, 0, 1, 7,  64'd42);
      cyc("after7",    7,  0, 0, 0, 0, 0,  '0);
      cyc("iss9",      0,  9, 1, 9, 0, 0,  '0);
      cyc("iss_wb9",   9,  9, 1, 9, 1, 9,  64'd1);
      cyc("after9",    9,  9, 0, 0, 0, 0,  '0);
      cyc("wb9",       9,  2, 0, 0, 1, 9,  64'd2);
      cyc("err_wb4",   4,  0, 0, 0, 1, 4,  64'd5);
      cyc("err_seen",  4,  0, 0, 0, 0, 0,  '0);
      cyc("err_stick", 4,  1, 0, 0, 0, 0,  '0);
      cyc("iss10",    10, 11, 1, 10, 0, 0, '0);
      cyc("iss11",    10, 11, 1, 11, 0, 0, '0);
      cyc("iss12",    12, 11, 1, 12, 0, 0, '0);
      cyc("reiss12",  12, 31, 1, 12, 0, 0, '0);
      cyc("iss_z",    12, 31, 1, 31, 0, 0, '0);
      async_reset("mid_reset");
      cyc("post_rst", 10, 12, 0, 0, 0, 0,  '0);
      cyc("byp6",      6,  6, 0, 0, 1, 6,  64'd77);
      cyc("after6",    6,  5, 0, 0, 0, 0,  '0);
      cyc("byp_iss",   8,  8, 1, 8, 1, 8,  64'd88);
      cyc("after8",    8,  8, 0, 0, 0, 0,  '0);

      for (int i = 0; i < 400; i++) begin
         int pick;
         if (i == 200) async_reset("rand_reset");
         pick = int'($urandom_range(0, 31));
         // bias writebacks toward currently pending registers
         if ($urandom_range(0, 3) != 0) begin
            for (int j = 0; j < 32; j++) begin
               if (mpend[(pick + j) % 32]) begin
                  pick = (pick + j) % 32;
                  break;
               end
            end
         end
         cyc("rand",
             int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
             bit'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
             bit'($urandom_range(0, 1)), pick,
             {$urandom, $urandom});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
